// File: rtl/alarm_arm_controller_if.sv
// Signal bundle between the alarm arming controller and its user/sensor/display side.
// The master drives sensors and user inputs; the slave (controller) drives status.
interface alarm_arm_controller_if;
  logic [3:0] sensors;
  logic [3:0] code_in;
  logic       btn_enter;
  logic [2:0] state;
  logic       armed;
  logic       siren;
  logic [3:0] countdown;
  logic [2:0] sensor_cnt;

  modport master (
    output sensors, code_in, btn_enter,
    input  state, armed, siren, countdown, sensor_cnt
  );

  modport slave (
    input  sensors, code_in, btn_enter,
    output state, armed, siren, countdown, sensor_cnt
  );
endinterface

// File: rtl/alarm_arm_controller.sv
// Arming/disarming FSM for the home alarm: user code entry, exit/entry countdowns,
// siren drive and display status, all outputs registered.
module alarm_arm_controller #(
  parameter int unsigned TICK_DIV    = 100_000_000,
  parameter int unsigned EXIT_DELAY  = 10,
  parameter int unsigned ENTRY_DELAY = 8,
  parameter logic [3:0]  ARM_CODE    = 4'hA,
  parameter int unsigned MAX_FAILS   = 3
) (
  input logic clk,
  input logic rst_n,
  alarm_arm_controller_if.slave bus
);

  localparam logic [2:0] ST_DISARMED = 3'd0;
  localparam logic [2:0] ST_EXIT     = 3'd1;
  localparam logic [2:0] ST_ARMED    = 3'd2;
  localparam logic [2:0] ST_ENTRY    = 3'd3;
  localparam logic [2:0] ST_ALARM    = 3'd4;

  localparam int unsigned PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  logic [3:0]    sensMeta_q, sensSync_q;
  logic [3:0]    codeMeta_q, codeSync_q;
  logic          btnMeta_q, btnSync_q, btnPrev_q;
  logic          commit_q, codeOk_q;
  logic [2:0]    state_q, state_d;
  logic [3:0]    count_q, count_d;
  logic [2:0]    fail_q, fail_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          armed_q, siren_q;
  logic [2:0]    sensorCnt_q;
  logic          tick, correctCommit, wrongCommit, failLimit;

  // The commit pulse and its code match are registered together, which gives the
  // three-cycle path from the first btn_enter sample to the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sensMeta_q  <= '0;
      sensSync_q  <= '0;
      codeMeta_q  <= '0;
      codeSync_q  <= '0;
      btnMeta_q   <= 1'b0;
      btnSync_q   <= 1'b0;
      btnPrev_q   <= 1'b0;
      commit_q    <= 1'b0;
      codeOk_q    <= 1'b0;
      sensorCnt_q <= '0;
    end else begin
      sensMeta_q  <= bus.sensors;
      sensSync_q  <= sensMeta_q;
      codeMeta_q  <= bus.code_in;
      codeSync_q  <= codeMeta_q;
      btnMeta_q   <= bus.btn_enter;
      btnSync_q   <= btnMeta_q;
      btnPrev_q   <= btnSync_q;
      commit_q    <= btnSync_q & ~btnPrev_q;
      codeOk_q    <= (codeSync_q == ARM_CODE);
      sensorCnt_q <= 3'($countones(sensSync_q));
    end
  end

  assign tick          = (presc_q == TICK_LAST);
  assign correctCommit = commit_q & codeOk_q;
  assign wrongCommit   = commit_q & ~codeOk_q;
  assign failLimit     = wrongCommit && (({1'b0, fail_q} + 4'd1) >= 4'(MAX_FAILS));

  // Event priority: correct commit, then fail limit, then tick expiry, then sensor trip.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    fail_d  = fail_q;
    case (state_q)
      ST_DISARMED: begin
        if (correctCommit) begin
          state_d = ST_EXIT;
          count_d = 4'(EXIT_DELAY);
        end
      end
      ST_EXIT: begin
        if (correctCommit) begin
          state_d = ST_DISARMED;
          count_d = '0;
        end else if (tick) begin
          if (count_q == 4'd1) begin
            state_d = ST_ARMED;
            count_d = '0;
          end else begin
            count_d = count_q - 4'd1;
          end
        end
      end
      ST_ARMED: begin
        if (correctCommit) begin
          state_d = ST_DISARMED;
        end else if (|sensSync_q) begin
          state_d = ST_ENTRY;
          count_d = 4'(ENTRY_DELAY);
          fail_d  = '0;
        end
      end
      ST_ENTRY: begin
        if (correctCommit) begin
          state_d = ST_DISARMED;
          count_d = '0;
        end else if (failLimit) begin
          state_d = ST_ALARM;
          count_d = '0;
          fail_d  = 3'(MAX_FAILS);
        end else begin
          if (wrongCommit) begin
            fail_d = fail_q + 3'd1;
          end
          if (tick) begin
            if (count_q == 4'd1) begin
              state_d = ST_ALARM;
              count_d = '0;
            end else begin
              count_d = count_q - 4'd1;
            end
          end
        end
      end
      ST_ALARM: begin
        if (correctCommit) begin
          state_d = ST_DISARMED;
        end
      end
      default: begin
        state_d = ST_DISARMED;
        count_d = '0;
      end
    endcase

    if (state_d != state_q || tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_DISARMED;
      count_q <= '0;
      fail_q  <= '0;
      presc_q <= '0;
      armed_q <= 1'b0;
      siren_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      fail_q  <= fail_d;
      presc_q <= presc_d;
      armed_q <= (state_d == ST_ARMED) || (state_d == ST_ENTRY) || (state_d == ST_ALARM);
      siren_q <= (state_d == ST_ALARM);
    end
  end

  assign bus.state      = state_q;
  assign bus.armed      = armed_q;
  assign bus.siren      = siren_q;
  assign bus.countdown  = count_q;
  assign bus.sensor_cnt = sensorCnt_q;

endmodule
